// File: rtl/rule_dedup_avlstrm_pkg.sv
// rule_dedup_avlstrm_pkg
//   Shared definitions for the rule-ID deduplication stage:
//   - stats register identifiers carried on the packed stats stream
//   - stats stream word layout: {reg_id[7:0], value[31:0]}
//   - stats_pack(): helper that builds one stats stream word
package rule_dedup_avlstrm_pkg;

  localparam int STATS_CNT_W = 32;
  localparam int STATS_ID_W  = 8;
  localparam int STATS_W     = STATS_ID_W + STATS_CNT_W;

  // Register identifiers; the value is the slot index on the stats stream.
  typedef enum logic [7:0] {
    REG_DD_IN_RULE  = 8'd0,
    REG_DD_OUT_RULE = 8'd1,
    REG_DD_DUP_RULE = 8'd2,
    REG_DD_OVF_PKT  = 8'd3
  } stats_t;

  localparam int N_STATS_DD = 4;

  function automatic logic [STATS_W-1:0] stats_pack(input logic [STATS_ID_W-1:0] id,
                                                   input logic [STATS_CNT_W-1:0] val);
    return {id, val};
  endfunction

endpackage

// File: rtl/rule_dedup_avlstrm_if.sv
// avl_stream_if
//   Avalon-ST style packet stream: valid/ready handshake with sop/eop framing.
//   Parameter W: data width.
//   Modports: tx/master drives the stream, rx/slave consumes it.
interface avl_stream_if #(parameter int W = 16);

  logic         valid;
  logic         ready;
  logic         sop;
  logic         eop;
  logic [W-1:0] data;

  modport tx     (output valid, output sop, output eop, output data, input ready);
  modport rx     (input valid, input sop, input eop, input data, output ready);
  modport master (output valid, output sop, output eop, output data, input ready);
  modport slave  (input valid, input sop, input eop, input data, output ready);

endinterface

// File: rtl/rule_dedup_avlstrm_hist_cam.sv
// rule_hist_cam
//   Per-packet history of unique rule IDs with a parallel lookup.
//   Ports:
//     Clk, Rst_n : clock, asynchronous active-low reset
//     clear      : start a new packet (fill count restarts at 0 this cycle)
//     write      : store wr_id at the current fill position if space remains
//     wr_id      : ID to store
//     lookup_id  : ID compared against entries 0..hcnt-1
//     hit        : lookup_id matches a valid entry (combinational)
//     full       : all HIST_DEPTH entries are in use
module rule_hist_cam #(
  parameter int RULE_W     = 16,
  parameter int HIST_DEPTH = 16
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              clear,
  input  logic              write,
  input  logic [RULE_W-1:0] wr_id,
  input  logic [RULE_W-1:0] lookup_id,
  output logic              hit,
  output logic              full
);

  localparam int IDX_W = $clog2(HIST_DEPTH);
  localparam int CNT_W = IDX_W + 1;

  logic [RULE_W-1:0]     entry_r [HIST_DEPTH];
  logic [CNT_W-1:0]      hcnt_r;
  logic [CNT_W-1:0]      base_s;
  logic                  room_s;
  logic [HIST_DEPTH-1:0] match_s;

  // Fill position for this cycle: a clear makes the incoming sop beat land in entry 0.
  always_comb begin
    base_s = clear ? {CNT_W{1'b0}} : hcnt_r;
    room_s = (base_s < CNT_W'(HIST_DEPTH));
  end

  // Parallel compare, masked to the entries filled so far in this packet.
  always_comb begin
    match_s = {HIST_DEPTH{1'b0}};
    for (int i = 0; i < HIST_DEPTH; i++) begin
      match_s[i] = (CNT_W'(i) < hcnt_r) && (entry_r[i] == lookup_id);
    end
  end

  assign hit  = |match_s;
  assign full = (hcnt_r == CNT_W'(HIST_DEPTH));

  // History storage and fill count.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      hcnt_r <= {CNT_W{1'b0}};
      for (int i = 0; i < HIST_DEPTH; i++) begin
        entry_r[i] <= {RULE_W{1'b0}};
      end
    end else if (write && room_s) begin
      entry_r[base_s[IDX_W-1:0]] <= wr_id;
      hcnt_r                     <= base_s + CNT_W'(1'b1);
    end else begin
      hcnt_r <= base_s;
    end
  end

endmodule

// File: rtl/rule_dedup_avlstrm_stats_packer.sv
// stats_packer_avlstrm
//   Serialises N_REGS 32-bit counters onto a stats stream, one counter per
//   beat, slot 0 with sop and slot N_REGS-1 with eop, repeating forever.
//   Ports:
//     Clk, Rst_n : clock, asynchronous active-low reset
//     vals       : counters, slot k at vals[32*k +: 32]
//     stats_out  : stream of stats_pack(slot, value) words
module stats_packer_avlstrm
  import rule_dedup_avlstrm_pkg::*;
#(
  parameter int N_REGS = 4
) (
  input  logic                          Clk,
  input  logic                          Rst_n,
  input  logic [N_REGS*STATS_CNT_W-1:0] vals,
  avl_stream_if.tx                      stats_out
);

  localparam int IDX_W = (N_REGS > 1) ? $clog2(N_REGS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REGS - 1);

  logic [IDX_W-1:0]   idx_r;
  logic               valid_r;
  logic               sop_r;
  logic               eop_r;
  logic [STATS_W-1:0] data_r;
  logic               load_s;

  assign load_s = !valid_r || stats_out.ready;

  // Output beat register; a new slot is loaded whenever the previous one is taken.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      idx_r   <= {IDX_W{1'b0}};
      valid_r <= 1'b0;
      sop_r   <= 1'b0;
      eop_r   <= 1'b0;
      data_r  <= {STATS_W{1'b0}};
    end else if (load_s) begin
      valid_r <= 1'b1;
      sop_r   <= (idx_r == {IDX_W{1'b0}});
      eop_r   <= (idx_r == IDX_LAST);
      data_r  <= stats_pack(STATS_ID_W'(idx_r), vals[STATS_CNT_W*idx_r +: STATS_CNT_W]);
      idx_r   <= (idx_r == IDX_LAST) ? {IDX_W{1'b0}} : idx_r + IDX_W'(1'b1);
    end
  end

  assign stats_out.valid = valid_r;
  assign stats_out.sop   = sop_r;
  assign stats_out.eop   = eop_r;
  assign stats_out.data  = data_r;

endmodule

// File: rtl/rule_dedup_avlstrm.sv
// rule_dedup_avlstrm
//   Per-packet rule-ID deduplication. Forwards only the first occurrence of
//   each rule ID inside a sop..eop packet while preserving framing: the last
//   unique beat is held back so a trailing duplicate eop can be folded into it.
//   Ports:
//     Clk, Rst_n      : clock, asynchronous active-low reset
//     in_rule         : rule beats in (valid/ready/sop/eop/data)
//     out_rule        : deduplicated rule beats out (registered)
//     stats_out       : packed stats stream (see rule_dedup_avlstrm_pkg)
//     stats_in_rule   : beats accepted on in_rule
//     stats_out_rule  : beats transferred on out_rule
//     stats_dup_rule  : beats dropped as duplicates
//     stats_ovf_pkt   : packets with more unique IDs than HIST_DEPTH
module rule_dedup_avlstrm
  import rule_dedup_avlstrm_pkg::*;
#(
  parameter int RULE_W     = 16,
  parameter int HIST_DEPTH = 16
) (
  input  logic        Clk,
  input  logic        Rst_n,
  avl_stream_if.rx    in_rule,
  avl_stream_if.tx    out_rule,
  avl_stream_if.tx    stats_out,
  output logic [31:0] stats_in_rule,
  output logic [31:0] stats_out_rule,
  output logic [31:0] stats_dup_rule,
  output logic [31:0] stats_ovf_pkt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HOLD  = 2'd1,
    FINAL = 2'd2
  } dd_state_t;

  dd_state_t state_r, next_state_s;

  logic              hold_sop_r, hold_eop_r;
  logic [RULE_W-1:0] hold_data_r;
  logic              out_valid_r, out_sop_r, out_eop_r;
  logic [RULE_W-1:0] out_data_r;
  logic              ovf_seen_r;

  logic outreg_free_s, in_ready_s, in_fire_s, dup_s, ovf_evt_s;
  logic hit_s, full_s;
  logic push_s, load_hold_s, mark_eop_s;

  // Beat qualification; in_rule.ready is combinational from out_rule.ready.
  always_comb begin
    outreg_free_s = !out_valid_r || out_rule.ready;
    in_ready_s    = (state_r != FINAL) && outreg_free_s;
    in_fire_s     = in_rule.valid && in_ready_s;
    dup_s         = !in_rule.sop && hit_s;
    // A sop beat always finds room since the history restarts with it.
    ovf_evt_s     = in_fire_s && !dup_s && !in_rule.sop && full_s && !ovf_seen_r;
  end

  assign in_rule.ready = in_ready_s;

  rule_hist_cam #(
    .RULE_W     (RULE_W),
    .HIST_DEPTH (HIST_DEPTH)
  ) u_hist (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .clear     (in_fire_s && in_rule.sop),
    .write     (in_fire_s && !dup_s),
    .wr_id     (in_rule.data),
    .lookup_id (in_rule.data),
    .hit       (hit_s),
    .full      (full_s)
  );

  // FSM state register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_r <= EMPTY;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next state and hold/output register controls.
  always_comb begin
    next_state_s = state_r;
    push_s       = 1'b0;
    load_hold_s  = 1'b0;
    mark_eop_s   = 1'b0;
    case (state_r)
      EMPTY: begin
        if (in_fire_s && !dup_s) begin
          load_hold_s  = 1'b1;
          next_state_s = in_rule.eop ? FINAL : HOLD;
        end else begin
          next_state_s = EMPTY;
        end
      end
      HOLD: begin
        if (in_fire_s && dup_s) begin
          // A duplicate eop still closes the packet: the held beat takes the eop.
          mark_eop_s   = in_rule.eop;
          next_state_s = in_rule.eop ? FINAL : HOLD;
        end else if (in_fire_s) begin
          push_s       = 1'b1;
          load_hold_s  = 1'b1;
          next_state_s = in_rule.eop ? FINAL : HOLD;
        end else begin
          next_state_s = HOLD;
        end
      end
      FINAL: begin
        if (outreg_free_s) begin
          push_s       = 1'b1;
          next_state_s = EMPTY;
        end else begin
          next_state_s = FINAL;
        end
      end
      default: begin
        next_state_s = EMPTY;
      end
    endcase
  end

  // Hold register: last unique beat of the current packet.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      hold_data_r <= {RULE_W{1'b0}};
      hold_sop_r  <= 1'b0;
      hold_eop_r  <= 1'b0;
    end else if (load_hold_s) begin
      hold_data_r <= in_rule.data;
      hold_sop_r  <= in_rule.sop;
      hold_eop_r  <= in_rule.eop;
    end else if (mark_eop_s) begin
      hold_eop_r  <= 1'b1;
    end
  end

  // Output register; data is left untouched while stalled.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      out_valid_r <= 1'b0;
      out_sop_r   <= 1'b0;
      out_eop_r   <= 1'b0;
      out_data_r  <= {RULE_W{1'b0}};
    end else if (push_s) begin
      out_valid_r <= 1'b1;
      out_sop_r   <= hold_sop_r;
      out_eop_r   <= hold_eop_r;
      out_data_r  <= hold_data_r;
    end else if (out_rule.ready) begin
      out_valid_r <= 1'b0;
    end
  end

  assign out_rule.valid = out_valid_r;
  assign out_rule.sop   = out_sop_r;
  assign out_rule.eop   = out_eop_r;
  assign out_rule.data  = out_data_r;

  // Overflow is counted once per packet; the flag rearms on every sop.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      ovf_seen_r <= 1'b0;
    end else if (in_fire_s && in_rule.sop) begin
      ovf_seen_r <= 1'b0;
    end else if (ovf_evt_s) begin
      ovf_seen_r <= 1'b1;
    end
  end

  // Event counters, wrapping modulo 2^32.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      stats_in_rule  <= 32'd0;
      stats_out_rule <= 32'd0;
      stats_dup_rule <= 32'd0;
      stats_ovf_pkt  <= 32'd0;
    end else begin
      if (in_fire_s)                    stats_in_rule  <= stats_in_rule + 32'd1;
      if (out_valid_r && out_rule.ready) stats_out_rule <= stats_out_rule + 32'd1;
      if (in_fire_s && dup_s)           stats_dup_rule <= stats_dup_rule + 32'd1;
      if (ovf_evt_s)                    stats_ovf_pkt  <= stats_ovf_pkt + 32'd1;
    end
  end

  stats_packer_avlstrm #(N_STATS_DD) u_stats (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .vals      ({stats_ovf_pkt, stats_dup_rule, stats_out_rule, stats_in_rule}),
    .stats_out (stats_out)
  );

endmodule
